// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard and forwarding controller: the forward-mux
// select encoding (same as the ID-stage forward mux), the shadow-stage record,
// and the stage-match rule used by both operand selectors.
package hazard_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_EX  = 2'd3
   } fwd_sel_e;

   // Shadow of one in-flight instruction: where it writes, whether it writes,
   // and whether the value only becomes available late (load).
   typedef struct packed {
      logic [REG_W-1:0] dst;
      logic             wr;
      logic             ld;
   } stage_t;

   // A stage can supply a source only if it really writes that register and
   // the register is not r0, which is hardwired to zero.
   function automatic logic stage_match(input logic [REG_W-1:0] dst,
                                        input logic             wr,
                                        input logic [REG_W-1:0] src);
      return wr && (dst == src) && (src != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select priority encoder for one ID source operand. The youngest
// matching stage wins, so a newer non-load writer in EX hides an older load in
// MEM. The load hazard flag is raised only when the winning stage is a load
// that has not yet reached WB.
module hazard_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             used,
   input  stage_t           ex_st,
   input  stage_t           mem_st,
   input  logic [REG_W-1:0] wb_dst,
   input  logic             wb_wr,
   output fwd_sel_e         sel,
   output logic             load_hazard
);

   // Pick the youngest stage holding the source and flag a not-yet-ready load.
   always_comb begin
      sel         = FWD_RF;
      load_hazard = 1'b0;
      if (used) begin
         if (stage_match(ex_st.dst, ex_st.wr, src)) begin
            sel         = FWD_EX;
            load_hazard = ex_st.ld;
         end else if (stage_match(mem_st.dst, mem_st.wr, src)) begin
            sel         = FWD_MEM;
            load_hazard = mem_st.ld;
         end else if (stage_match(wb_dst, wb_wr, src)) begin
            sel         = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Keeps a shadow of
// the EX, MEM and WB destination/write/load bits, drives the ID forward selects,
// the load-use stall (PC hold, IF/ID hold, ID/EX bubble), the IF/ID flush on a
// redirect, and a saturating count of stall cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_redirect,
   output logic [1:0]       forward1,
   output logic [1:0]       forward2,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_t           ex_st;
   stage_t           mem_st;
   logic [REG_W-1:0] wb_dst;
   logic             wb_wr;

   fwd_sel_e         sel_rs;
   fwd_sel_e         sel_rt;
   logic             hz_rs;
   logic             hz_rt;
   logic             stall;

   hazard_fwd_sel u_sel_rs (
      .src         (id_rs),
      .used        (id_uses_rs),
      .ex_st       (ex_st),
      .mem_st      (mem_st),
      .wb_dst      (wb_dst),
      .wb_wr       (wb_wr),
      .sel         (sel_rs),
      .load_hazard (hz_rs)
   );

   hazard_fwd_sel u_sel_rt (
      .src         (id_rt),
      .used        (id_uses_rt),
      .ex_st       (ex_st),
      .mem_st      (mem_st),
      .wb_dst      (wb_dst),
      .wb_wr       (wb_wr),
      .sel         (sel_rt),
      .load_hazard (hz_rt)
   );

   assign stall = hz_rs | hz_rt;

   // Advance the shadow pipeline one stage; a stalled ID instruction enters EX as a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_st  <= '0;
         mem_st <= '0;
         wb_dst <= '0;
         wb_wr  <= 1'b0;
      end else begin
         wb_dst <= mem_st.dst;
         wb_wr  <= mem_st.wr;
         mem_st <= ex_st;
         if (stall) begin
            ex_st <= '0;
         end else begin
            ex_st.dst <= id_dst;
            ex_st.wr  <= id_reg_write;
            ex_st.ld  <= id_mem_read;
         end
      end
   end

   // Count stall cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + CNT_ONE;
      end
   end

   // Pipeline control: a stall freezes PC and IF/ID, bubbles ID/EX and suppresses the redirect.
   always_comb begin
      forward1      = sel_rs;
      forward2      = sel_rt;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_bubble   = 1'b0;
      ifid_flush    = id_redirect;
      if (stall) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_bubble   = 1'b1;
         ifid_flush    = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a queue-style model of the three
// in-flight instructions is checked against the DUT every cycle, with directed
// scenarios pinning literal values and a small-counter instance for saturation.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_uses_rs = 1'b0;
   logic       id_uses_rt = 1'b0;
   logic [4:0] id_dst = '0;
   logic       id_reg_write = 1'b0;
   logic       id_mem_read = 1'b0;
   logic       id_redirect = 1'b0;

   logic [1:0]  forward1, forward2;
   logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
   logic [31:0] stall_count;

   logic [1:0]  s_forward1, s_forward2;
   logic        s_pc_write_en, s_ifid_write_en, s_ifid_flush, s_idex_bubble;
   logic [2:0]  s_stall_count;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_redirect(id_redirect),
      .forward1(forward1), .forward2(forward2), .pc_write_en(pc_write_en),
      .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .stall_count(stall_count)
   );

   hazard_ctrl #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_redirect(id_redirect),
      .forward1(s_forward1), .forward2(s_forward2), .pc_write_en(s_pc_write_en),
      .ifid_write_en(s_ifid_write_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
      .stall_count(s_stall_count)
   );

   always #5 clk = ~clk;

   // Model: in-flight writers, index 0 = youngest (EX), 1 = MEM, 2 = WB.
   logic [4:0] m_dst [3];
   bit         m_wr  [3];
   bit         m_ld  [3];
   longint     m_cnt;
   int         m_cnt_sat;
   bit         m_st;

   // Age (0..2) of the youngest in-flight writer of src, or -1 when none supplies it.
   function automatic int youngest(input logic [4:0] src, input bit used);
      if (!used || src == 0) return -1;
      for (int i = 0; i < 3; i++)
         if (m_wr[i] && m_dst[i] == src) return i;
      return -1;
   endfunction

   function automatic int model_fwd(input logic [4:0] src, input bit used);
      int a;
      a = youngest(src, used);
      return (a < 0) ? 0 : 3 - a;
   endfunction

   // Load data only exists at WB, so a load still in EX or MEM blocks its consumer.
   function automatic bit model_stall();
      int a, b;
      a = youngest(id_rs, id_uses_rs);
      b = youngest(id_rt, id_uses_rt);
      return (a >= 0 && a < 2 && m_ld[a]) || (b >= 0 && b < 2 && m_ld[b]);
   endfunction

   // Model state advance, mirroring the pipeline's one-stage-per-cycle movement.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_dst[i] = '0; m_wr[i] = 0; m_ld[i] = 0;
         end
         m_cnt = 0;
         m_cnt_sat = 0;
      end else begin
         m_st = model_stall();
         for (int i = 2; i > 0; i--) begin
            m_dst[i] = m_dst[i-1]; m_wr[i] = m_wr[i-1]; m_ld[i] = m_ld[i-1];
         end
         if (m_st) begin
            m_dst[0] = '0; m_wr[0] = 0; m_ld[0] = 0;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt_sat < 7) m_cnt_sat++;
         end else begin
            m_dst[0] = id_dst; m_wr[0] = id_reg_write; m_ld[0] = id_mem_read;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      bit st;
      int f1, f2;
      st = model_stall();
      f1 = model_fwd(id_rs, id_uses_rs);
      f2 = model_fwd(id_rt, id_uses_rt);
      checkOutput("m_forward1", 64'(forward1), 64'(f1));
      checkOutput("m_forward2", 64'(forward2), 64'(f2));
      checkOutput("m_pc_write_en", 64'(pc_write_en), 64'(!st));
      checkOutput("m_ifid_write_en", 64'(ifid_write_en), 64'(!st));
      checkOutput("m_idex_bubble", 64'(idex_bubble), 64'(st));
      checkOutput("m_ifid_flush", 64'(ifid_flush), 64'(!st && id_redirect));
      checkOutput("m_stall_count", 64'(stall_count), 64'(m_cnt));
      checkOutput("m_sat_forward1", 64'(s_forward1), 64'(f1));
      checkOutput("m_sat_forward2", 64'(s_forward2), 64'(f2));
      checkOutput("m_sat_ctrl", 64'({s_pc_write_en, s_ifid_write_en, s_idex_bubble, s_ifid_flush}),
                  64'({!st, !st, st, !st && id_redirect}));
      checkOutput("m_sat_count", 64'(s_stall_count), 64'(m_cnt_sat));
   end

   // Present one instruction in ID just after the next rising edge.
   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input bit urs, input bit urt, input logic [4:0] dst,
                                input bit wr, input bit ld, input bit redir);
      @(posedge clk);
      #1;
      id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_reg_write = wr; id_mem_read = ld; id_redirect = redir;
   endtask

   task automatic pulseReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      // Reset state with no writers.
      #12;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_forward1", 64'(forward1), 64'd0);
      checkOutput("rst_forward2", 64'(forward2), 64'd0);
      checkOutput("rst_pc_write_en", 64'(pc_write_en), 64'd1);
      checkOutput("rst_stall_count", 64'(stall_count), 64'd0);

      // Producer add r3 followed by consumers at distance 1, 2, 3, 4.
      pulseReset();
      applyStimulus(0, 0, 0, 0, 3, 1, 0, 0);
      applyStimulus(3, 5, 1, 1, 4, 1, 0, 0);
      @(negedge clk); checkOutput("fwd_ex", 64'(forward1), 64'd3);
      applyStimulus(3, 5, 1, 1, 4, 1, 0, 0);
      @(negedge clk); checkOutput("fwd_mem", 64'(forward1), 64'd2);
      applyStimulus(3, 5, 1, 1, 4, 1, 0, 0);
      @(negedge clk); checkOutput("fwd_wb", 64'(forward1), 64'd1);
      applyStimulus(3, 5, 1, 1, 4, 1, 0, 0);
      @(negedge clk); checkOutput("fwd_rf", 64'(forward1), 64'd0);

      // lw r2 then beq r2,r0 (taken): two stall cycles, then forward from WB and flush.
      pulseReset();
      applyStimulus(0, 0, 0, 0, 2, 1, 1, 0);
      applyStimulus(2, 0, 1, 1, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("lu_stall1_pc", 64'(pc_write_en), 64'd0);
      checkOutput("lu_stall1_bubble", 64'(idex_bubble), 64'd1);
      checkOutput("lu_stall1_flush", 64'(ifid_flush), 64'd0);
      @(negedge clk);
      checkOutput("lu_stall2_pc", 64'(pc_write_en), 64'd0);
      checkOutput("lu_stall2_flush", 64'(ifid_flush), 64'd0);
      @(negedge clk);
      checkOutput("lu_after_pc", 64'(pc_write_en), 64'd1);
      checkOutput("lu_after_fwd1", 64'(forward1), 64'd1);
      checkOutput("lu_after_flush", 64'(ifid_flush), 64'd1);
      checkOutput("lu_count", 64'(stall_count), 64'd2);

      // Newer add r7 in EX hides lw r7 in MEM; writes to r0 never forward or stall.
      pulseReset();
      applyStimulus(0, 0, 0, 0, 7, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 7, 1, 0, 0);
      applyStimulus(7, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("young_fwd1", 64'(forward1), 64'd3);
      checkOutput("young_pc", 64'(pc_write_en), 64'd1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("r0_fwd1", 64'(forward1), 64'd0);
      checkOutput("r0_fwd2", 64'(forward2), 64'd0);
      checkOutput("r0_pc", 64'(pc_write_en), 64'd1);

      // Reset asserted during the first load-use stall cycle.
      pulseReset();
      applyStimulus(0, 0, 0, 0, 2, 1, 1, 0);
      applyStimulus(2, 0, 1, 1, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("mid_pre_pc", 64'(pc_write_en), 64'd0);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_pc", 64'(pc_write_en), 64'd1);
      checkOutput("mid_bubble", 64'(idex_bubble), 64'd0);
      checkOutput("mid_count", 64'(stall_count), 64'd0);
      checkOutput("mid_fwd1", 64'(forward1), 64'd0);
      #1 rst = 1'b0;

      // Saturation on the 3-bit counter: reach 6 then push past 7.
      pulseReset();
      for (int r = 0; r < 5; r++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
         applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
         @(posedge clk);
         @(posedge clk);
         if (r == 2) begin
            @(negedge clk);
            checkOutput("sat_pre", 64'(s_stall_count), 64'd6);
         end
      end
      @(negedge clk);
      checkOutput("sat_hold", 64'(s_stall_count), 64'd7);
      checkOutput("sat_wide", 64'(stall_count), 64'd10);

      // Randomized traffic over a small register range, with occasional reset.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
         end
      end

      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
